// File: rtl/mips_alu.sv
// Registered MIPS-style ALU for the execute stage: AND/OR/ADD/SUB/SLT/NOR with
// zero and signed-overflow flags, one cycle of latency, loaded only on in_valid.
module mips_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_ctl,
    input  logic             in_valid,
    output logic [WIDTH-1:0] alu_out,
    output logic             zero,
    output logic             overflow,
    output logic             out_valid
);

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100
    } alu_op_e;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_add_ov;
    logic             w_sub_ov;
    logic             w_slt;
    logic [WIDTH-1:0] w_result;
    logic             w_ov;

    logic [WIDTH-1:0] r_alu_out;
    logic             r_zero;
    logic             r_overflow;
    logic             r_out_valid;

    assign w_sum    = a + b;
    assign w_diff   = a - b;
    assign w_add_ov = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
    assign w_sub_ov = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
    // Difference sign corrected by overflow gives the true signed a < b.
    assign w_slt    = w_diff[WIDTH-1] ^ w_sub_ov;

    // NOTE: every output of this block gets a default first, so unlisted
    // opcodes cannot infer a latch.
    always_comb begin
        w_result = '0;
        w_ov     = 1'b0;
        case (alu_op_e'(alu_ctl))
            ALU_AND: w_result = a & b;
            ALU_OR:  w_result = a | b;
            ALU_ADD: begin
                w_result = w_sum;
                w_ov     = w_add_ov;
            end
            ALU_SUB: begin
                w_result = w_diff;
                w_ov     = w_sub_ov;
            end
            ALU_SLT: w_result = {{(WIDTH-1){1'b0}}, w_slt};
            ALU_NOR: w_result = ~(a | b);
            default: begin
                w_result = '0;
                w_ov     = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; zero is taken
    // from the value being loaded so it always agrees with alu_out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_alu_out   <= '0;
            r_zero      <= 1'b1;
            r_overflow  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_alu_out  <= w_result;
                r_zero     <= (w_result == '0);
                r_overflow <= w_ov;
            end
        end
    end

    assign alu_out   = r_alu_out;
    assign zero      = r_zero;
    assign overflow  = r_overflow;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mips_alu.sv
// Self-checking bench for mips_alu: directed cases plus randomized operations
// compared against an integer-arithmetic reference model.
module tb_mips_alu;

    logic       clk;
    logic       reset;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] alu_ctl;
    logic       in_valid;
    logic [7:0] alu_out;
    logic       zero;
    logic       overflow;
    logic       out_valid;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state: what the outputs should currently show.
    logic [7:0] m_out;
    logic       m_ov;
    logic       m_valid;

    mips_alu #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .a         (a),
        .b         (b),
        .alu_ctl   (alu_ctl),
        .in_valid  (in_valid),
        .alu_out   (alu_out),
        .zero      (zero),
        .overflow  (overflow),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Operands treated as signed integers; results derived from plain arithmetic.
    function automatic void ref_op(input logic [7:0] x, input logic [7:0] y,
                                   input logic [3:0] c,
                                   output logic [7:0] r, output logic ov);
        int sx;
        int sy;
        int s;
        sx = int'($signed(x));
        sy = int'($signed(y));
        r  = 8'h00;
        ov = 1'b0;
        case (c)
            4'd0:  r = x & y;
            4'd1:  r = x | y;
            4'd2: begin
                s  = sx + sy;
                r  = s[7:0];
                ov = (s > 127) || (s < -128);
            end
            4'd6: begin
                s  = sx - sy;
                r  = s[7:0];
                ov = (s > 127) || (s < -128);
            end
            4'd7:  r = (sx < sy) ? 8'h01 : 8'h00;
            4'd12: r = ~(x | y);
            default: begin
                r  = 8'h00;
                ov = 1'b0;
            end
        endcase
    endfunction

    task automatic check_model(input string tag);
        check({tag, ".out"},   alu_out,   m_out);
        check({tag, ".zero"},  zero,      (m_out == 8'h00));
        check({tag, ".ovf"},   overflow,  m_ov);
        check({tag, ".valid"}, out_valid, m_valid);
    endtask

    // Drive one cycle of inputs, step the model, sample 1 ns after the edge.
    task automatic step(input logic [7:0] ia, input logic [7:0] ib,
                        input logic [3:0] ctl, input logic v);
        logic [7:0] r;
        logic       ov;
        a        = ia;
        b        = ib;
        alu_ctl  = ctl;
        in_valid = v;
        @(posedge clk);
        #1;
        if (v) begin
            ref_op(ia, ib, ctl, r, ov);
            m_out = r;
            m_ov  = ov;
        end
        m_valid = v;
    endtask

    initial begin
        reset    = 1'b1;
        a        = 8'h00;
        b        = 8'h00;
        alu_ctl  = 4'h0;
        in_valid = 1'b0;
        m_out    = 8'h00;
        m_ov     = 1'b0;
        m_valid  = 1'b0;

        // Reset state, with in_valid high across an edge to show reset wins.
        in_valid = 1'b1;
        alu_ctl  = 4'b0001;
        a        = 8'h55;
        b        = 8'h0F;
        repeat (2) @(posedge clk);
        #1;
        check("rst.out",   alu_out,   8'h00);
        check("rst.zero",  zero,      1'b1);
        check("rst.ovf",   overflow,  1'b0);
        check("rst.valid", out_valid, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b0;

        // Logic operations.
        step(8'h01, 8'h03, 4'b0000, 1'b1);
        check("and.out", alu_out, 8'h01);
        check("and.zero", zero, 1'b0);
        check_model("and");
        step(8'h02, 8'h05, 4'b0001, 1'b1);
        check("or.out", alu_out, 8'h07);
        check_model("or");
        step(8'h07, 8'h11, 4'b1100, 1'b1);
        check("nor.out", alu_out, 8'hE8);
        check_model("nor");

        // Asynchronous reset mid-operation, away from any clock edge.
        #2 reset = 1'b1;
        #1;
        check("arst.out",   alu_out,   8'h00);
        check("arst.zero",  zero,      1'b1);
        check("arst.ovf",   overflow,  1'b0);
        check("arst.valid", out_valid, 1'b0);
        @(negedge clk);
        reset   = 1'b0;
        m_out   = 8'h00;
        m_ov    = 1'b0;
        m_valid = 1'b0;

        // Arithmetic, including signed overflow at both extremes.
        step(8'h22, 8'h0B, 4'b0010, 1'b1);
        check("add.out", alu_out, 8'h2D);
        check("add.ovf", overflow, 1'b0);
        check_model("add");
        step(8'h0C, 8'h03, 4'b0110, 1'b1);
        check("sub.out", alu_out, 8'h09);
        check_model("sub");
        step(8'h7F, 8'h01, 4'b0010, 1'b1);
        check("addov.out", alu_out, 8'h80);
        check("addov.ovf", overflow, 1'b1);
        step(8'h80, 8'h01, 4'b0110, 1'b1);
        check("subov.out", alu_out, 8'h7F);
        check("subov.ovf", overflow, 1'b1);
        step(8'h05, 8'h05, 4'b0110, 1'b1);
        check("subz.out", alu_out, 8'h00);
        check("subz.zero", zero, 1'b1);
        check("subz.ovf", overflow, 1'b0);

        // Set-less-than, signed.
        step(8'h35, 8'h19, 4'b0111, 1'b1);
        check("slt1.out", alu_out, 8'h00);
        check("slt1.zero", zero, 1'b1);
        step(8'h19, 8'h35, 4'b0111, 1'b1);
        check("slt2.out", alu_out, 8'h01);
        step(8'h80, 8'h7F, 4'b0111, 1'b1);
        check("slt3.out", alu_out, 8'h01);
        step(8'h7F, 8'h80, 4'b0111, 1'b1);
        check("slt4.out", alu_out, 8'h00);
        check_model("slt4");

        // Undefined opcode.
        step(8'hFF, 8'hFF, 4'b1111, 1'b1);
        check("undef.out", alu_out, 8'h00);
        check("undef.zero", zero, 1'b1);
        check("undef.ovf", overflow, 1'b0);

        // Hold when in_valid is low, then back-to-back valid operations.
        step(8'h22, 8'h0B, 4'b0010, 1'b1);
        check("hold0.out", alu_out, 8'h2D);
        step(8'hF0, 8'h0F, 4'b0001, 1'b0);
        check("hold1.out", alu_out, 8'h2D);
        check("hold1.valid", out_valid, 1'b0);
        check_model("hold1");
        step(8'h10, 8'h20, 4'b0010, 1'b1);
        check("b2b0.out", alu_out, 8'h30);
        check("b2b0.valid", out_valid, 1'b1);
        step(8'h10, 8'h20, 4'b0110, 1'b1);
        check("b2b1.out", alu_out, 8'hF0);
        step(8'hC3, 8'h3C, 4'b0000, 1'b1);
        check("b2b2.out", alu_out, 8'h00);
        check("b2b2.zero", zero, 1'b1);

        // Randomized operations against the reference model.
        for (int i = 0; i < 300; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            logic [3:0] rc;
            logic       rv;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 4'($urandom_range(0, 15));
            rv = ($urandom_range(0, 3) != 0);
            step(ra, rb, rc, rv);
            check_model($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mips_alu.md
Name: mips_alu

Overview:
- Registered 8-bit MIPS-style ALU for the datapath execute stage.
- Takes two operands and a 4-bit ALU control code from the ALU-control decoder.
- Produces a registered result, a zero flag (for branch compare) and a signed-overflow flag, one clock after the operands are presented.

Parameters:
- WIDTH, 8, operand and result width in bits. All values below assume 8.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- a  input  WIDTH  operand A (rs).
- b  input  WIDTH  operand B (rt / immediate).
- alu_ctl  input  4  operation select.
- in_valid  input  1  operands/control valid this cycle; result register loads only when high.
- alu_out  output  WIDTH  registered result.
- zero  output  1  registered; 1 iff alu_out == 0.
- overflow  output  1  registered signed overflow of ADD/SUB; 0 for all other ops.
- out_valid  output  1  registered copy of in_valid (1-cycle latency).

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset). Asserting reset immediately forces:
  - alu_out = 0
  - zero = 1 (consistent with alu_out = 0)
  - overflow = 0
  - out_valid = 0
- Reset takes effect regardless of clk and wins over in_valid.
- Latency: exactly 1 cycle. Inputs sampled at posedge clk with in_valid = 1 appear on outputs after that edge.
- in_valid = 0 at a posedge: alu_out, zero and overflow hold their previous values; out_valid becomes 0.
- Back-to-back in_valid is allowed every cycle; no backpressure, no stall.
- Operation decode (result computed combinationally, then registered):
  - 0000 AND: a & b.
  - 0001 OR: a | b.
  - 0010 ADD: (a + b) mod 2^WIDTH. overflow = a and b share a sign bit and the result's sign bit differs.
  - 0110 SUB: (a − b) mod 2^WIDTH. overflow = a and b have different sign bits and the result's sign bit differs from a's.
  - 0111 SLT: 1 if a < b as two's-complement signed values, else 0; zero-extended to WIDTH.
  - 1100 NOR: ~(a | b).
  - Any other code: result 0, overflow 0 (so zero = 1).
- Arithmetic:
  - Carry-out is discarded.
  - SLT uses the true signed comparison, i.e. the sign of the subtraction corrected by overflow. Correct at extremes, e.g. 0x80 < 0x7F → 1.
- zero is computed from the value being registered, not from a combinational compare of the inputs.
- If reset deasserts near a clock edge, the first post-reset result is the first posedge with reset low and in_valid high.
- No internal state beyond the output registers; purely a registered combinational datapath.

Test Plan:
- Reset: assert reset mid-operation (after a non-zero result) → outputs immediately alu_out = 0x00, zero = 1, overflow = 0, out_valid = 0.
- Logic ops, one edge each with in_valid = 1:
  - AND a=0x01, b=0x03 → alu_out = 0x01, zero = 0.
  - OR a=0x02, b=0x05 → alu_out = 0x07.
  - NOR a=0x07, b=0x11 → alu_out = 0xE8.
- Arithmetic:
  - ADD a=0x22, b=0x0B → 0x2D, overflow = 0.
  - SUB a=0x0C, b=0x03 → 0x09.
  - ADD a=0x7F, b=0x01 → 0x80, overflow = 1.
  - SUB a=0x80, b=0x01 → 0x7F, overflow = 1.
  - SUB a=0x05, b=0x05 → 0x00, zero = 1.
- SLT:
  - a=0x35, b=0x19 → 0x00, zero = 1.
  - a=0x19, b=0x35 → 0x01.
  - a=0x80, b=0x7F → 0x01 (signed).
  - a=0x7F, b=0x80 → 0x00.
- Undefined alu_ctl = 1111 with a=0xFF, b=0xFF → alu_out = 0x00, zero = 1, overflow = 0.
- Hold/valid:
  - Load ADD 0x22+0x0B.
  - Next cycle in_valid = 0 with new operands → alu_out stays 0x2D, out_valid = 0.
  - Back-to-back valid ops each produce their result exactly one cycle later.
